// File: rtl/mem_wb_stage.sv
// Memory/writeback pipeline stage: byte-enabled synchronous data RAM, load formatting, branch resolution.
// Optional build macro MISALIGN_TRAP_EN turns misaligned half/word accesses into traps.
module mem_wb_stage #(
   parameter int ADDR_W = 8,
   parameter int PC_W   = 5,
   parameter int RD_W   = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [PC_W-1:0] in_pc,
   input  logic [31:0]     in_alu_res,
   input  logic [31:0]     in_store_data,
   input  logic [2:0]      in_jump_type,
   input  logic            in_reg_wr,
   input  logic            in_mem_wr,
   input  logic            in_mem_rd,
   input  logic [1:0]      in_size,
   input  logic            in_unsigned,
   input  logic [RD_W-1:0] in_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [RD_W-1:0] out_rd,
   output logic            out_reg_wr,
   output logic [31:0]     out_wb_data,
   output logic            should_jump,
   output logic            out_trap
);

   typedef enum logic [1:0] {EMPTY, LOAD_PEND, FULL} state_t;

   state_t            state;
   logic [31:0]       mem [2**ADDR_W];
   logic [31:0]       ram_q;
   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        offset;
   logic              accept;
   logic              misalign;
   logic              is_store;
   logic              is_load;
   logic              taken;
   logic [3:0]        lane_en;
   logic [31:0]       wr_data;
   logic [1:0]        ld_off;
   logic [1:0]        ld_size;
   logic              ld_unsigned;
   logic              jump_q;
   logic              trap_q;
   logic              unused_addr;

   assign in_ready    = (state == EMPTY) || ((state == FULL) && out_ready);
   assign accept      = in_valid && in_ready;
   assign word_idx    = in_alu_res[ADDR_W+1:2];
   assign offset      = in_alu_res[1:0];
   assign unused_addr = ^in_alu_res[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
   assign misalign = (in_mem_wr || in_mem_rd) &&
                     ((in_size == 2'b01) ? offset[0] : (in_size[1] && (offset != 2'b00)));
`else
   assign misalign = 1'b0;
`endif

   // A store in the same bundle wins over a load; a trapped access touches no memory.
   assign is_store = accept && in_mem_wr && !misalign;
   assign is_load  = accept && in_mem_rd && !in_mem_wr && !misalign;

   assign taken = in_jump_type[2] ? (in_jump_type[1] ? (in_alu_res != 32'd0) : (in_alu_res == 32'd0))
                                  : in_jump_type[0];

   always_comb begin
      lane_en = 4'b1111;
      wr_data = in_store_data;
      case (in_size)
         2'b00: begin
            lane_en = 4'b0001 << offset;
            wr_data = {4{in_store_data[7:0]}};
         end
         2'b01: begin
            lane_en = offset[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{in_store_data[15:0]}};
         end
         default: begin
            lane_en = 4'b1111;
            wr_data = in_store_data;
         end
      endcase
   end

   // RAM contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (is_store) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
      if (is_load) ram_q <= mem[word_idx];
   end

   function automatic logic [31:0] format_load(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] sz, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*off +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   format_load = uns ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   format_load = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: format_load = w;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= EMPTY;
         out_pc      <= '0;
         out_rd      <= '0;
         out_reg_wr  <= 1'b0;
         out_wb_data <= '0;
         jump_q      <= 1'b0;
         trap_q      <= 1'b0;
         ld_off      <= '0;
         ld_size     <= '0;
         ld_unsigned <= 1'b0;
      end else begin
         case (state)
            LOAD_PEND: begin
               out_wb_data <= format_load(ram_q, ld_off, ld_size, ld_unsigned);
               state       <= FULL;
            end
            default: begin
               if (accept) begin
                  out_pc      <= in_pc;
                  out_rd      <= in_rd;
                  out_reg_wr  <= in_reg_wr && !misalign;
                  out_wb_data <= in_alu_res;
                  jump_q      <= taken && !misalign;
                  trap_q      <= misalign;
                  ld_off      <= offset;
                  ld_size     <= in_size;
                  ld_unsigned <= in_unsigned;
                  state       <= is_load ? LOAD_PEND : FULL;
               end else if ((state == FULL) && out_ready) begin
                  state <= EMPTY;
               end
            end
         endcase
      end
   end

   assign out_valid   = (state == FULL);
   assign should_jump = jump_q && out_valid;
   assign out_trap    = trap_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: byte-addressed reference memory model plus directed and random bundles.
// Honours MISALIGN_TRAP_EN the same way as the design.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_pc = '0;
   logic [31:0] in_alu_res = '0;
   logic [31:0] in_store_data = '0;
   logic [2:0]  in_jump_type = '0;
   logic        in_reg_wr = 1'b0;
   logic        in_mem_wr = 1'b0;
   logic        in_mem_rd = 1'b0;
   logic [1:0]  in_size = '0;
   logic        in_unsigned = 1'b0;
   logic [4:0]  in_rd = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [4:0]  out_pc;
   logic [4:0]  out_rd;
   logic        out_reg_wr;
   logic [31:0] out_wb_data;
   logic        should_jump;
   logic        out_trap;

   int checks = 0;
   int passes = 0;
   logic [7:0] ref_mem [1024];

   mem_wb_stage #(.ADDR_W(8), .PC_W(5), .RD_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_alu_res(in_alu_res), .in_store_data(in_store_data), .in_jump_type(in_jump_type),
      .in_reg_wr(in_reg_wr), .in_mem_wr(in_mem_wr), .in_mem_rd(in_mem_rd), .in_size(in_size),
      .in_unsigned(in_unsigned), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rd(out_rd), .out_reg_wr(out_reg_wr), .out_wb_data(out_wb_data),
      .should_jump(should_jump), .out_trap(out_trap)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference memory is byte addressed and little endian; naturally aligned base per size.
   task automatic model_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
      int a;
      a = int'(addr[9:0]);
      if (sz == 2'b00) begin
         ref_mem[a] = data[7:0];
      end else if (sz == 2'b01) begin
         a = a - (a % 2);
         ref_mem[a]     = data[7:0];
         ref_mem[a + 1] = data[15:8];
      end else begin
         a = a - (a % 4);
         for (int k = 0; k < 4; k++) ref_mem[a + k] = data[8*k +: 8];
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
      int a;
      logic [31:0] v;
      a = int'(addr[9:0]);
      if (sz == 2'b00) begin
         v = {24'd0, ref_mem[a]};
         if (!uns && v[7]) v = v - 32'd256;
      end else if (sz == 2'b01) begin
         a = a - (a % 2);
         v = {16'd0, ref_mem[a + 1], ref_mem[a]};
         if (!uns && v[15]) v = v - 32'd65536;
      end else begin
         a = a - (a % 4);
         v = {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
      end
      return v;
   endfunction

   function automatic logic model_jump(input logic [2:0] jt, input logic [31:0] alu);
      if (jt[2]) return jt[1] ? (alu != 0) : (alu == 0);
      return jt[0];
   endfunction

   function automatic logic model_misalign(input logic mw, input logic mr, input logic [31:0] addr,
                                           input logic [1:0] sz);
`ifdef MISALIGN_TRAP_EN
      if (!(mw || mr)) return 1'b0;
      if (sz == 2'b01) return (addr % 2) != 0;
      if (sz >= 2'b10) return (addr % 4) != 0;
      return 1'b0;
`else
      return 1'b0 && mw && mr && (addr != 0) && (sz != 0);
`endif
   endfunction

   // Drives one bundle, waits for its acceptance, then captures the resulting writeback bundle.
   task automatic issue(input logic [4:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [2:0] jt, input logic rw, input logic mw, input logic mr,
                        input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                        output int lat, output logic [4:0] o_pc, output logic [4:0] o_rd,
                        output logic o_rw, output logic [31:0] o_wb, output logic o_sj,
                        output logic o_trap);
      int n;
      @(negedge clk);
      in_pc = pc; in_alu_res = alu; in_store_data = sd; in_jump_type = jt; in_reg_wr = rw;
      in_mem_wr = mw; in_mem_rd = mr; in_size = sz; in_unsigned = uns; in_rd = rd;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0; o_pc = 'x; o_rd = 'x; o_rw = 'x; o_wb = 'x; o_sj = 'x; o_trap = 'x;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = c; o_pc = out_pc; o_rd = out_rd; o_rw = out_reg_wr;
            o_wb = out_wb_data; o_sj = should_jump; o_trap = out_trap;
            break;
         end
      end
   endtask

   task automatic test_reset();
      in_valid = 1'b1; in_alu_res = $urandom; in_pc = 5'd9; in_rd = 5'd3; in_reg_wr = 1'b1;
      in_jump_type = 3'b001; out_ready = 1'b1;
      #2 rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 5'd0 || out_rd !== 5'd0 ||
             out_reg_wr !== 1'b0 || out_wb_data !== 32'd0 || should_jump !== 1'b0 || out_trap !== 1'b0)
            $display("[TB] FAIL reset_state: got valid=%b ready=%b pc=%h rd=%h rw=%b wb=%h sj=%b trap=%b expected ready=1 and all else 0",
                     out_valid, in_ready, out_pc, out_rd, out_reg_wr, out_wb_data, should_jump, out_trap);
         else passes++;
      end
      in_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   // Fills every RAM word with back-to-back stores; one bundle must emerge per cycle.
   task automatic test_back_to_back();
      logic [31:0] d;
      out_ready = 1'b1;
      for (int w = 0; w < 256; w++) begin
         @(negedge clk);
         if (w > 0) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_pc !== 5'(w - 1) || out_wb_data !== 32'((w - 1) * 4))
               $display("[TB] FAIL stream_%0d: got ready=%b valid=%b pc=%h wb=%h expected ready=1 valid=1 pc=%h wb=%h",
                        w, in_ready, out_valid, out_pc, out_wb_data, 5'(w - 1), 32'((w - 1) * 4));
            else passes++;
         end
         d = $urandom;
         in_pc = 5'(w); in_alu_res = 32'(w * 4); in_store_data = d; in_jump_type = 3'b000;
         in_reg_wr = 1'b0; in_mem_wr = 1'b1; in_mem_rd = 1'b0; in_size = 2'b10; in_unsigned = 1'b0;
         in_valid = 1'b1;
         model_store(32'(w * 4), 2'b10, d);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 5'd31) $display("[TB] FAIL stream_last: got valid=%b pc=%h expected 1 1f", out_valid, out_pc);
      else passes++;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) $display("[TB] FAIL stream_drain: got valid=%b expected 0", out_valid);
      else passes++;
   endtask

   task automatic test_loads();
      int lat; logic [4:0] p, r; logic rw, sj, tr; logic [31:0] wb;
      logic [31:0] alus [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
      logic [1:0]  szs  [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
      logic        unss [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] exps [4] = '{32'h000000DE, 32'hFFFFFFDE, 32'hFFFFDEAD, 32'hDEADBEEF};
      issue(5'd1, 32'h10, 32'hDEADBEEF, 3'b000, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd0, lat, p, r, rw, wb, sj, tr);
      model_store(32'h10, 2'b10, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) begin
         issue(5'(i + 2), alus[i], 32'd0, 3'b000, 1'b1, 1'b0, 1'b1, szs[i], unss[i], 5'd7, lat, p, r, rw, wb, sj, tr);
         checks++;
         if (wb !== exps[i] || lat != 2 || r !== 5'd7 || rw !== 1'b1)
            $display("[TB] FAIL load_%0d: got wb=%h lat=%0d rd=%h rw=%b expected wb=%h lat=2 rd=07 rw=1", i, wb, lat, r, rw, exps[i]);
         else passes++;
      end
      issue(5'd6, 32'h11, 32'h00000055, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd0, lat, p, r, rw, wb, sj, tr);
      model_store(32'h11, 2'b00, 32'h55);
      issue(5'd7, 32'h10, 32'd0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd4, lat, p, r, rw, wb, sj, tr);
      checks++;
      if (wb !== 32'hDEAD55EF) $display("[TB] FAIL sb_merge: got %h expected DEAD55EF", wb);
      else passes++;
   endtask

   task automatic test_branches();
      int lat; logic [4:0] p, r; logic rw, sj, tr; logic [31:0] wb;
      logic [2:0]  jts  [5] = '{3'b100, 3'b110, 3'b110, 3'b001, 3'b000};
      logic [31:0] alus [5] = '{32'd0, 32'd0, 32'd7, 32'd5, 32'd0};
      logic        exps [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         issue(5'(i + 10), alus[i], 32'd0, jts[i], 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd0, lat, p, r, rw, wb, sj, tr);
         checks++;
         if (sj !== exps[i] || lat != 1 || p !== 5'(i + 10))
            $display("[TB] FAIL branch_%0d: got jump=%b lat=%0d pc=%h expected jump=%b lat=1 pc=%h", i, sj, lat, p, exps[i], 5'(i + 10));
         else passes++;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] b_data;
      int lat; logic [4:0] p, r; logic rw, sj, tr; logic [31:0] wb;
      b_data = $urandom;
      @(negedge clk);
      out_ready = 1'b0;
      in_pc = 5'd20; in_alu_res = 32'h1234; in_jump_type = 3'b001; in_reg_wr = 1'b1;
      in_mem_wr = 1'b0; in_mem_rd = 1'b0; in_size = 2'b10; in_rd = 5'd2; in_valid = 1'b1;
      @(posedge clk);
      #1 in_pc = 5'd21; in_alu_res = 32'h40; in_store_data = b_data; in_jump_type = 3'b000;
      in_reg_wr = 1'b0; in_mem_wr = 1'b1; in_rd = 5'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 5'd20 || out_wb_data !== 32'h1234 ||
             should_jump !== 1'b1 || out_rd !== 5'd2)
            $display("[TB] FAIL stall_%0d: got ready=%b valid=%b pc=%h wb=%h jump=%b rd=%h expected 0 1 14 00001234 1 02",
                     i, in_ready, out_valid, out_pc, out_wb_data, should_jump, out_rd);
         else passes++;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      model_store(32'h40, 2'b10, b_data);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 5'd21 || out_wb_data !== 32'h40)
         $display("[TB] FAIL release: got valid=%b pc=%h wb=%h expected 1 15 00000040", out_valid, out_pc, out_wb_data);
      else passes++;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) $display("[TB] FAIL no_duplicate: got valid=%b expected 0", out_valid);
      else passes++;
      issue(5'd22, 32'h40, 32'd0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd1, lat, p, r, rw, wb, sj, tr);
      checks++;
      if (wb !== model_load(32'h40, 2'b10, 1'b0)) $display("[TB] FAIL stall_store: got %h expected %h", wb, model_load(32'h40, 2'b10, 1'b0));
      else passes++;
   endtask

   task automatic test_misalign();
      int lat; logic [4:0] p, r; logic rw, sj, tr; logic [31:0] wb;
      logic exp_trap;
      exp_trap = model_misalign(1'b1, 1'b0, 32'h12, 2'b10);
      issue(5'd23, 32'h12, 32'hCAFEF00D, 3'b001, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 5'd5, lat, p, r, rw, wb, sj, tr);
      if (!exp_trap) model_store(32'h12, 2'b10, 32'hCAFEF00D);
      checks++;
      if (tr !== exp_trap || rw !== !exp_trap || sj !== !exp_trap || lat != 1)
         $display("[TB] FAIL misalign_store: got trap=%b rw=%b jump=%b lat=%0d expected trap=%b rw=%b jump=%b lat=1",
                  tr, rw, sj, lat, exp_trap, !exp_trap, !exp_trap);
      else passes++;
      issue(5'd24, 32'h10, 32'd0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd5, lat, p, r, rw, wb, sj, tr);
      checks++;
      if (wb !== model_load(32'h10, 2'b10, 1'b0) || tr !== 1'b0)
         $display("[TB] FAIL misalign_after: got wb=%h trap=%b expected wb=%h trap=0", wb, tr, model_load(32'h10, 2'b10, 1'b0));
      else passes++;
   endtask

   task automatic test_reset_during_load();
      int lat; logic [4:0] p, r; logic rw, sj, tr; logic [31:0] wb;
      logic [31:0] d;
      d = $urandom;
      issue(5'd25, 32'h80, d, 3'b000, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd0, lat, p, r, rw, wb, sj, tr);
      model_store(32'h80, 2'b10, d);
      @(negedge clk);
      in_pc = 5'd26; in_alu_res = 32'h80; in_mem_wr = 1'b0; in_mem_rd = 1'b1; in_size = 2'b10;
      in_reg_wr = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) $display("[TB] FAIL aborted_load_%0d: got valid=%b expected 0", i, out_valid);
         else passes++;
      end
      issue(5'd27, 32'h80, 32'd0, 3'b000, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 5'd9, lat, p, r, rw, wb, sj, tr);
      checks++;
      if (wb !== d || lat != 2) $display("[TB] FAIL store_survives_reset: got wb=%h lat=%0d expected %h lat=2", wb, lat, d);
      else passes++;
   endtask

   task automatic test_random();
      int lat; logic [4:0] p, r; logic rw, sj, tr; logic [31:0] wb;
      logic [31:0] alu, sd, exp_wb;
      logic [2:0] jt; logic [1:0] sz; logic mw, mr, uns, rwi, mis, ld;
      logic [4:0] pc, rd;
      int kind, exp_lat;
      for (int i = 0; i < 80; i++) begin
         kind = $urandom_range(0, 2);
         alu = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         sd = $urandom; jt = 3'($urandom); sz = 2'($urandom); uns = 1'($urandom);
         rwi = 1'($urandom); pc = 5'($urandom); rd = 5'($urandom);
         mw = (kind == 1); mr = (kind == 2) || (kind == 1 && $urandom_range(0, 1) == 1);
         mis = model_misalign(mw, mr, alu, sz);
         ld = mr && !mw && !mis;
         issue(pc, alu, sd, jt, rwi, mw, mr, sz, uns, rd, lat, p, r, rw, wb, sj, tr);
         exp_wb = ld ? model_load(alu, sz, uns) : alu;
         exp_lat = ld ? 2 : 1;
         if (mw && !mis) model_store(alu, sz, sd);
         checks++;
         if (wb !== exp_wb || lat != exp_lat || p !== pc || r !== rd || rw !== (rwi && !mis) ||
             sj !== (model_jump(jt, alu) && !mis) || tr !== mis)
            $display("[TB] FAIL random_%0d: got wb=%h lat=%0d pc=%h rd=%h rw=%b jump=%b trap=%b expected wb=%h lat=%0d pc=%h rd=%h rw=%b jump=%b trap=%b",
                     i, wb, lat, p, r, rw, sj, tr, exp_wb, exp_lat, pc, rd, rwi && !mis,
                     model_jump(jt, alu) && !mis, mis);
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_loads();
      test_branches();
      test_backpressure();
      test_misalign();
      test_reset_during_load();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parameterised memory/writeback stage of the pipelined CPU, sitting between execute and register-file writeback. It owns a byte-enabled synchronous data RAM and performs byte, half and word loads and stores with sign or zero extension. It resolves branches and jumps and presents a registered writeback bundle under a valid/ready handshake on both sides, so upstream and downstream can stall.

## Interface
- ADDR_W, 8, word-address bits; RAM depth is 2^ADDR_W 32-bit words
- PC_W, 5, PC width
- RD_W, 5, destination register index width
- clk input 1 system clock, rising edge
- rst_n input 1 asynchronous, active-low reset
- in_valid input 1 upstream bundle valid
- in_ready output 1 stage can accept this cycle
- in_pc input PC_W instruction PC
- in_alu_res input 32 ALU result, also the byte address
- in_store_data input 32 store data, LSB-aligned
- in_jump_type input 3 [2] is branch; [1] 1=bne, 0=beq; [0] unconditional jump when [2]=0
- in_reg_wr input 1 writes register file
- in_mem_wr input 1 store
- in_mem_rd input 1 load
- in_size input 2 00 byte, 01 half, 10 word; 11 treated as word
- in_unsigned input 1 zero-extend loads
- in_rd input RD_W destination register
- out_valid output 1 writeback bundle valid
- out_ready input 1 downstream accepts
- out_pc output PC_W
- out_rd output RD_W
- out_reg_wr output 1
- out_wb_data output 32 formatted load data or ALU result
- should_jump output 1 branch/jump taken, forced 0 when out_valid=0
- out_trap output 1 misaligned-access trap (see Configuration)

## Operation
- Accept = in_valid && in_ready. Word index = in_alu_res[ADDR_W+1:2]; offset = in_alu_res[1:0]; upper address bits ignored.
- Stores commit to RAM at the accept edge. Byte: enable lane offset, data replicated. Half: lanes {2*offset[1], 2*offset[1]+1}. Word: all four lanes.
- Loads: RAM read is registered; data returned one cycle after accept. Byte selects lane offset, half selects half offset[1], then sign-extends unless in_unsigned.
- out_wb_data = formatted load data when the op was a load, else in_alu_res.
- Jump resolution at accept: if jump_type[2], taken = jump_type[1] ? (alu_res != 0) : (alu_res == 0); else taken = jump_type[0].
- Loads and stores in the same bundle: in_mem_wr has priority; in_mem_rd ignored.
- State machine: EMPTY, LOAD_PEND, FULL.
  - in_ready = (EMPTY) || (FULL && out_ready); 0 in LOAD_PEND.
  - EMPTY: accept load -> LOAD_PEND; accept other -> FULL; else stay.
  - LOAD_PEND -> FULL unconditionally; load data captured into out_wb_data.
  - FULL && out_ready: accept load -> LOAD_PEND; accept other -> FULL (bundle replaced); no accept -> EMPTY.
  - FULL && !out_ready: hold every output stable.
- out_valid = (state == FULL).

## Timing
- Reset (async assert, sync-safe deassert): state EMPTY; out_valid, should_jump, out_trap, out_reg_wr = 0; out_pc, out_rd, out_wb_data = 0. RAM contents not reset.
- Latency accept -> out_valid: 1 cycle non-load, 2 cycles load.
- Throughput: 1/cycle for non-loads with out_ready high; a load inserts one bubble.
- Store at accept cycle N, load of same word accepted at N+1 or later returns the new data.
- Reset during LOAD_PEND aborts the load; no bundle emitted; earlier committed stores remain.

## Configuration
- MISALIGN_TRAP_EN defined: half with offset[0]=1 or word with offset!=0 is misaligned. Store is suppressed, no RAM read is issued, state goes straight to FULL with out_trap=1, out_reg_wr=0, should_jump=0.
- Undefined: no check. Half ignores offset[0], word ignores offset[1:0], access proceeds. out_trap tied 0.

## Test plan
- Reset with in_valid=1 -> out_valid=0, in_ready=1, all outputs 0 until rst_n rises.
- Store word 0xDEADBEEF @0x10, then lbu @0x13 -> out_wb_data=0x000000DE; lb -> 0xFFFFFFDE; lh @0x12 -> 0xFFFFDEAD; lw @0x10 -> 0xDEADBEEF, each 2 cycles after accept.
- sb 0x55 @0x11 over 0xDEADBEEF, then lw @0x10 -> 0xDEAD55EF.
- Branches: jump_type=3'b100 with alu_res=0 -> should_jump=1; 3'b110 with alu_res=0 -> 0; 3'b110 with alu_res=7 -> 1; 3'b001 -> 1; 3'b000 -> 0.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no store committed; out_ready=1 -> next bundle out 1 cycle later, nothing lost or duplicated.
- With MISALIGN_TRAP_EN, sw @0x12 then lw @0x10 -> out_trap=1 on the store bundle, memory unchanged. Without the macro, the same store writes word 0x10.
